// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap controller for the ButterFly RV32IM core.
// Optional 64-bit cycle/instret counters are built only when CSR_COUNTERS_EN is defined.
module csr_trap_unit #(
    parameter int          NUM_PLAT_IRQ = 4,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter logic [31:0] HART_ID      = 32'd0,
    parameter int          CNT_W        = 64,
    localparam int         PLAT_W       = (NUM_PLAT_IRQ > 0) ? NUM_PLAT_IRQ : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              csr_en_i,
    input  logic [1:0]        csr_op_i,
    input  logic [11:0]       csr_addr_i,
    input  logic [31:0]       csr_wdata_i,
    output logic [31:0]       csr_rdata_o,
    output logic              csr_illegal_o,
    input  logic              instret_i,
    input  logic              exception_i,
    input  logic [31:0]       exception_pc_i,
    input  logic [4:0]        exception_cause_i,
    input  logic [31:0]       exception_tval_i,
    input  logic              irq_ext_i,
    input  logic              irq_timer_i,
    input  logic              irq_soft_i,
    input  logic [PLAT_W-1:0] irq_plat_i,
    input  logic [31:0]       irq_pc_i,
    input  logic              irq_allow_i,
    input  logic              mret_i,
    output logic              trap_taken_o,
    output logic [31:0]       trap_vector_o,
    output logic              mret_taken_o,
    output logic [31:0]       mepc_o,
    output logic              irq_pending_o
);

    localparam logic [31:0] MIE_MASK = 32'h0000_0888 |
                                       (((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [31:0] w_mip;
    logic [31:0] w_pend;
    logic [31:0] w_mstatus;
    logic [4:0]  w_irq_code;
    logic        w_irq_take;
    logic        w_trap;
    logic        w_mret_take;
    logic [31:0] w_rd_val;
    logic        w_impl;
    logic        w_ro;
    logic [31:0] w_wval;
    logic        w_we;
    logic [31:0] w_vec_base;

`ifdef CSR_COUNTERS_EN
    logic [CNT_W-1:0] r_mcycle;
    logic [CNT_W-1:0] r_minstret;
    logic             w_unused_bits;
    assign w_unused_bits = ^{exception_pc_i[1:0], irq_pc_i[1:0]};
`else
    logic             w_unused_bits;
    assign w_unused_bits = ^{exception_pc_i[1:0], irq_pc_i[1:0], instret_i};
`endif

    always_comb begin
        w_mip     = '0;
        w_mip[3]  = irq_soft_i;
        w_mip[7]  = irq_timer_i;
        w_mip[11] = irq_ext_i;
        for (int i = 0; i < NUM_PLAT_IRQ; i++) begin
            w_mip[16+i] = irq_plat_i[i];
        end
    end

    assign w_pend    = r_mie & w_mip;
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    // Later assignments win: platform lines scanned high-to-low, then MTI, MSI, MEI.
    always_comb begin
        w_irq_code = 5'd0;
        for (int i = NUM_PLAT_IRQ - 1; i >= 0; i--) begin
            if (w_pend[16+i]) w_irq_code = 5'(16 + i);
        end
        if (w_pend[7])  w_irq_code = 5'd7;
        if (w_pend[3])  w_irq_code = 5'd3;
        if (w_pend[11]) w_irq_code = 5'd11;
    end

    assign w_irq_take  = irq_allow_i & r_mstatus_mie & (|w_pend);
    assign w_trap      = exception_i | w_irq_take;
    assign w_mret_take = mret_i & ~w_trap;
    assign w_vec_base  = {r_mtvec[31:2], 2'b00};

    always_comb begin
        trap_vector_o = 32'd0;
        if (w_trap) begin
            if (!exception_i && r_mtvec[1:0] == 2'b01)
                trap_vector_o = w_vec_base + {25'd0, w_irq_code, 2'b00};
            else
                trap_vector_o = w_vec_base;
        end else if (w_mret_take) begin
            trap_vector_o = r_mepc;
        end
    end

    assign trap_taken_o  = w_trap;
    assign mret_taken_o  = w_mret_take;
    assign mepc_o        = r_mepc;
    assign irq_pending_o = |w_pend;

    always_comb begin
        w_rd_val = 32'd0;
        w_impl   = 1'b1;
        w_ro     = 1'b0;
        case (csr_addr_i)
            12'h300: w_rd_val = w_mstatus;
            12'h301: begin w_rd_val = 32'h4000_1100; w_ro = 1'b1; end
            12'h304: w_rd_val = r_mie;
            12'h305: w_rd_val = r_mtvec;
            12'h340: w_rd_val = r_mscratch;
            12'h341: w_rd_val = r_mepc;
            12'h342: w_rd_val = r_mcause;
            12'h343: w_rd_val = r_mtval;
            12'h344: begin w_rd_val = w_mip; w_ro = 1'b1; end
            12'hF14: begin w_rd_val = HART_ID; w_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
            12'hB00: w_rd_val = r_mcycle[31:0];
            12'hB80: w_rd_val = 32'(r_mcycle[CNT_W-1:32]);
            12'hB02: w_rd_val = r_minstret[31:0];
            12'hB82: w_rd_val = 32'(r_minstret[CNT_W-1:32]);
            12'hC00: begin w_rd_val = r_mcycle[31:0]; w_ro = 1'b1; end
            12'hC80: begin w_rd_val = 32'(r_mcycle[CNT_W-1:32]); w_ro = 1'b1; end
            12'hC02: begin w_rd_val = r_minstret[31:0]; w_ro = 1'b1; end
            12'hC82: begin w_rd_val = 32'(r_minstret[CNT_W-1:32]); w_ro = 1'b1; end
`endif
            default: w_impl = 1'b0;
        endcase
    end

    assign csr_rdata_o   = csr_en_i ? w_rd_val : 32'd0;
    assign csr_illegal_o = csr_en_i & (~w_impl | (w_ro & (csr_op_i != 2'b00)));

    always_comb begin
        case (csr_op_i)
            2'b01:   w_wval = csr_wdata_i;
            2'b10:   w_wval = w_rd_val | csr_wdata_i;
            2'b11:   w_wval = w_rd_val & ~csr_wdata_i;
            default: w_wval = w_rd_val;
        endcase
    end

    // Trap entry and mret own the cycle; a CSR write alongside them is dropped.
    assign w_we = csr_en_i & (csr_op_i != 2'b00) & w_impl & ~w_ro & ~w_trap & ~w_mret_take;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_mtvec        <= MTVEC_RESET;
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
        end else if (w_trap) begin
            r_mepc         <= exception_i ? {exception_pc_i[31:2], 2'b00}
                                          : {irq_pc_i[31:2], 2'b00};
            r_mcause       <= exception_i ? {27'd0, exception_cause_i}
                                          : {1'b1, 26'd0, w_irq_code};
            r_mtval        <= exception_i ? exception_tval_i : 32'd0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_mret_take) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we) begin
            case (csr_addr_i)
                12'h300: begin
                    r_mstatus_mie  <= w_wval[3];
                    r_mstatus_mpie <= w_wval[7];
                end
                12'h304: r_mie <= w_wval & MIE_MASK;
                // Reserved MODE encodings keep the previous mode; BASE always updates.
                12'h305: r_mtvec <= {w_wval[31:2], w_wval[1] ? r_mtvec[1:0] : w_wval[1:0]};
                12'h340: r_mscratch <= w_wval;
                12'h341: r_mepc     <= {w_wval[31:2], 2'b00};
                12'h342: r_mcause   <= w_wval;
                12'h343: r_mtval    <= w_wval;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_we && csr_addr_i == 12'hB00)
                r_mcycle[31:0] <= w_wval;
            else if (w_we && csr_addr_i == 12'hB80)
                r_mcycle[CNT_W-1:32] <= w_wval[CNT_W-33:0];
            else
                r_mcycle <= r_mcycle + CNT_W'(1);

            if (w_we && csr_addr_i == 12'hB02)
                r_minstret[31:0] <= w_wval;
            else if (w_we && csr_addr_i == 12'hB82)
                r_minstret[CNT_W-1:32] <= w_wval[CNT_W-33:0];
            else if (instret_i)
                r_minstret <= r_minstret + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - directed and randomized checks of csr_trap_unit against a behavioural model.
module tb_csr_trap_unit;

    localparam int NP = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        csr_en_i;
    logic [1:0]  csr_op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        instret_i;
    logic        exception_i;
    logic [31:0] exception_pc_i;
    logic [4:0]  exception_cause_i;
    logic [31:0] exception_tval_i;
    logic        irq_ext_i, irq_timer_i, irq_soft_i;
    logic [NP-1:0] irq_plat_i;
    logic [31:0] irq_pc_i;
    logic        irq_allow_i;
    logic        mret_i;
    logic        trap_taken_o;
    logic [31:0] trap_vector_o;
    logic        mret_taken_o;
    logic [31:0] mepc_o;
    logic        irq_pending_o;

    always #5 clk_i = ~clk_i;

    csr_trap_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .instret_i(instret_i), .exception_i(exception_i), .exception_pc_i(exception_pc_i),
        .exception_cause_i(exception_cause_i), .exception_tval_i(exception_tval_i),
        .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_soft_i(irq_soft_i),
        .irq_plat_i(irq_plat_i), .irq_pc_i(irq_pc_i), .irq_allow_i(irq_allow_i),
        .mret_i(mret_i), .trap_taken_o(trap_taken_o), .trap_vector_o(trap_vector_o),
        .mret_taken_o(mret_taken_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
    );

    // Architectural state of the reference model
    bit          m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    // Expectations for the current cycle
    logic [31:0] e_rdata, e_vec, e_nv;
    bit          e_ill, e_trap, e_mret, e_we, e_pend;
    int          e_code;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] MIE_W = 32'h888 | (((32'h1 << NP) - 32'h1) << 16);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] csr_value(input logic [11:0] a, output bit known, output bit ro);
        known = 1'b1;
        ro    = 1'b0;
        case (a)
            12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h301: begin ro = 1'b1; return 32'h4000_1100; end
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: begin
                ro = 1'b1;
                return (32'(irq_soft_i) << 3) | (32'(irq_timer_i) << 7) |
                       (32'(irq_ext_i) << 11) | (32'(irq_plat_i) << 16);
            end
            12'hF14: begin ro = 1'b1; return 32'd0; end
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hC00: begin ro = 1'b1; return m_cyc[31:0]; end
            12'hC80: begin ro = 1'b1; return m_cyc[63:32]; end
            12'hC02: begin ro = 1'b1; return m_ins[31:0]; end
            12'hC82: begin ro = 1'b1; return m_ins[63:32]; end
`endif
            default: begin known = 1'b0; return 32'd0; end
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mie_r = 0; m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    task automatic eval();
        logic [31:0] mip, pend, old, base;
        bit known, ro;
        int prio[$];
        mip  = (32'(irq_soft_i) << 3) | (32'(irq_timer_i) << 7) |
               (32'(irq_ext_i) << 11) | (32'(irq_plat_i) << 16);
        pend = m_mie_r & mip;
        old  = csr_value(csr_addr_i, known, ro);
        e_ill   = csr_en_i && (!known || (csr_op_i != 0 && ro));
        e_rdata = (csr_en_i && known) ? old : 32'd0;
        e_pend  = (pend != 0);
        e_trap  = exception_i || (irq_allow_i && m_mie && e_pend);
        prio = '{11, 3, 7};
        for (int i = 0; i < NP; i++) prio.push_back(16 + i);
        e_code = 0;
        foreach (prio[k]) if (pend[prio[k]] && e_code == 0) e_code = prio[k];
        e_mret = mret_i && !e_trap;
        base   = m_mtvec & ~32'h3;
        if (e_trap)      e_vec = (!exception_i && m_mtvec[1:0] == 2'b01) ? base + 32'(e_code) * 4 : base;
        else if (e_mret) e_vec = m_mepc;
        else             e_vec = 32'd0;
        e_we = csr_en_i && csr_op_i != 0 && known && !ro && !e_trap && !e_mret;
        case (csr_op_i)
            2'd1:    e_nv = csr_wdata_i;
            2'd2:    e_nv = old | csr_wdata_i;
            2'd3:    e_nv = old & ~csr_wdata_i;
            default: e_nv = old;
        endcase
    endtask

    task automatic commit();
        if (e_trap) begin
            m_mepc   = (exception_i ? exception_pc_i : irq_pc_i) & ~32'h3;
            m_mcause = exception_i ? 32'(exception_cause_i) : (32'h8000_0000 | 32'(e_code));
            m_mtval  = exception_i ? exception_tval_i : 32'd0;
            m_mpie   = m_mie;
            m_mie    = 0;
        end else if (e_mret) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end else if (e_we) begin
            case (csr_addr_i)
                12'h300: begin m_mie = e_nv[3]; m_mpie = e_nv[7]; end
                12'h304: m_mie_r = e_nv & MIE_W;
                12'h305: begin
                    m_mtvec[31:2] = e_nv[31:2];
                    if (e_nv[1:0] < 2) m_mtvec[1:0] = e_nv[1:0];
                end
                12'h340: m_mscratch = e_nv;
                12'h341: m_mepc = e_nv & ~32'h3;
                12'h342: m_mcause = e_nv;
                12'h343: m_mtval = e_nv;
                default: ;
            endcase
        end
`ifdef CSR_COUNTERS_EN
        if (e_we && csr_addr_i == 12'hB00)      m_cyc[31:0]  = e_nv;
        else if (e_we && csr_addr_i == 12'hB80) m_cyc[63:32] = e_nv;
        else                                    m_cyc        = m_cyc + 1;
        if (e_we && csr_addr_i == 12'hB02)      m_ins[31:0]  = e_nv;
        else if (e_we && csr_addr_i == 12'hB82) m_ins[63:32] = e_nv;
        else if (instret_i)                     m_ins        = m_ins + 1;
`endif
    endtask

    task automatic idle();
        csr_en_i = 0; csr_op_i = 0; csr_addr_i = 0; csr_wdata_i = 0; instret_i = 0;
        exception_i = 0; exception_pc_i = 0; exception_cause_i = 0; exception_tval_i = 0;
        irq_ext_i = 0; irq_timer_i = 0; irq_soft_i = 0; irq_plat_i = 0; irq_pc_i = 0;
        irq_allow_i = 0; mret_i = 0;
    endtask

    task automatic settle();
        #4;
        eval();
        chk("rdata", csr_rdata_o, e_rdata);
        chk("illegal", 32'(csr_illegal_o), 32'(e_ill));
        chk("trap_taken", 32'(trap_taken_o), 32'(e_trap));
        chk("trap_vector", trap_vector_o, e_vec);
        chk("mret_taken", 32'(mret_taken_o), 32'(e_mret));
        chk("mepc_o", mepc_o, m_mepc);
        chk("irq_pending", 32'(irq_pending_o), 32'(e_pend));
    endtask

    task automatic tick();
        @(posedge clk_i);
        commit();
        #1;
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        idle();
        csr_en_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = d;
        settle();
        tick();
    endtask

    task automatic rd_exp(input logic [11:0] a, input logic [31:0] exp, input string tag);
        idle();
        csr_en_i = 1; csr_addr_i = a;
        settle();
        chk(tag, csr_rdata_o, exp);
        tick();
    endtask

    logic [11:0] addr_tab [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB02,
                                   12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                                   12'h7C0, 12'hC01};

    initial begin
        idle();
        rst_i = 1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;

        idle();
        settle();
        chk("rst_trap", 32'(trap_taken_o), 32'd0);
        chk("rst_mret", 32'(mret_taken_o), 32'd0);
        chk("rst_mepc", mepc_o, 32'd0);
        chk("rst_pend", 32'(irq_pending_o), 32'd0);
        tick();

        rd_exp(12'h305, 32'h0000_0100, "mtvec_reset");
        rd_exp(12'h301, 32'h4000_1100, "misa");
        rd_exp(12'h300, 32'h0000_1800, "mstatus_reset");

        csr(2'd2, 12'h300, 32'h8);
        csr(2'd1, 12'h304, 32'h800);
        idle();
        irq_ext_i = 1; irq_allow_i = 1; irq_pc_i = 32'h44;
        settle();
        chk("mei_trap", 32'(trap_taken_o), 32'd1);
        chk("mei_vector", trap_vector_o, 32'h0000_0100);
        tick();
        rd_exp(12'h342, 32'h8000_000B, "mei_mcause");
        rd_exp(12'h300, 32'h0000_1880, "mei_mstatus");

        csr(2'd1, 12'h305, 32'h0000_2001);
        csr(2'd2, 12'h300, 32'h8);
        csr(2'd1, 12'h304, 32'h80);
        idle();
        irq_timer_i = 1; irq_allow_i = 1;
        settle();
        chk("mti_vectored", trap_vector_o, 32'h0000_201C);
        tick();
        csr(2'd2, 12'h300, 32'h8);
        idle();
        irq_timer_i = 1; irq_allow_i = 1; exception_i = 1; exception_cause_i = 5'd5;
        exception_pc_i = 32'h40;
        settle();
        chk("exc_wins_vector", trap_vector_o, 32'h0000_2000);
        tick();
        rd_exp(12'h342, 32'h5, "exc_wins_mcause");

        idle();
        exception_i = 1; exception_cause_i = 5'd2; exception_pc_i = 32'h80;
        csr_en_i = 1; csr_op_i = 2'd1; csr_addr_i = 12'h340; csr_wdata_i = 32'hDEAD_BEEF;
        settle();
        tick();
        rd_exp(12'h341, 32'h80, "exc_mepc");
        rd_exp(12'h342, 32'h2, "exc_mcause");
        rd_exp(12'h340, 32'h0, "exc_mscratch_kept");
        idle();
        mret_i = 1;
        settle();
        chk("mret_taken", 32'(mret_taken_o), 32'd1);
        chk("mret_target", trap_vector_o, 32'h80);
        tick();

`ifdef CSR_COUNTERS_EN
        csr(2'd1, 12'hB00, 32'hFFFF_FFFF);
        csr(2'd1, 12'hB80, 32'h0);
        idle();
        settle();
        tick();
        rd_exp(12'hB80, 32'h1, "mcycleh_carry");
        csr(2'd1, 12'hB00, 32'h1234);
        rd_exp(12'hB00, 32'h1234, "mcycle_write_beats_inc");
        idle();
        instret_i = 1; csr_en_i = 1; csr_op_i = 2'd1; csr_addr_i = 12'hB02; csr_wdata_i = 32'd7;
        settle();
        tick();
        rd_exp(12'hB02, 32'd7, "minstret_write_beats_inc");
`else
        idle();
        csr_en_i = 1; csr_addr_i = 12'hB00;
        settle();
        chk("mcycle_absent_illegal", 32'(csr_illegal_o), 32'd1);
        chk("mcycle_absent_rdata", csr_rdata_o, 32'd0);
        tick();
`endif

        idle();
        csr_en_i = 1; csr_addr_i = 12'h7C0;
        settle();
        chk("unimpl_illegal", 32'(csr_illegal_o), 32'd1);
        chk("unimpl_rdata", csr_rdata_o, 32'd0);
        tick();
        idle();
        csr_en_i = 1; csr_op_i = 2'd1; csr_addr_i = 12'h301; csr_wdata_i = 32'h0;
        settle();
        chk("misa_write_illegal", 32'(csr_illegal_o), 32'd1);
        tick();
        rd_exp(12'h301, 32'h4000_1100, "misa_unchanged");

        for (int n = 0; n < 400; n++) begin
            idle();
            csr_en_i          = 1'($urandom_range(0, 1));
            csr_op_i          = 2'($urandom_range(0, 3));
            csr_addr_i        = addr_tab[$urandom_range(0, 19)];
            csr_wdata_i       = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15)) << 2;
            instret_i         = 1'($urandom_range(0, 1));
            exception_i       = ($urandom_range(0, 7) == 0);
            exception_pc_i    = $urandom & ~32'h3;
            exception_cause_i = 5'($urandom_range(0, 15));
            exception_tval_i  = $urandom;
            irq_ext_i         = ($urandom_range(0, 3) == 0);
            irq_timer_i       = ($urandom_range(0, 3) == 0);
            irq_soft_i        = ($urandom_range(0, 3) == 0);
            irq_plat_i        = NP'($urandom);
            irq_pc_i          = $urandom & ~32'h3;
            irq_allow_i       = 1'($urandom_range(0, 1));
            mret_i            = ($urandom_range(0, 7) == 0);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
